// File: rtl/stream_arb_mux_n.sv
// N-input valid/ready stream multiplexer with round-robin or fixed-priority arbitration,
// optional packet locking and a single-entry registered output stage.
module stream_arb_mux_n #(
    parameter int NUM_INPUTS   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ARB_MODE     = 0,
    parameter int LOCK_PACKETS = 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [NUM_INPUTS-1:0]                  i_in_valid,
    output logic [NUM_INPUTS-1:0]                  o_in_ready,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  i_in_data,
    input  logic [NUM_INPUTS-1:0]                  i_in_last,
    output logic                                   o_out_valid,
    input  logic                                   i_out_ready,
    output logic [DATA_WIDTH-1:0]                  o_out_data,
    output logic                                   o_out_last,
    output logic [$clog2(NUM_INPUTS)-1:0]          o_out_src
);

    localparam int SEL_W = $clog2(NUM_INPUTS);

    if (NUM_INPUTS < 2) begin : g_bad_num_inputs
        $fatal(1, "stream_arb_mux_n: NUM_INPUTS must be >= 2");
    end
    if (ARB_MODE != 0 && ARB_MODE != 1) begin : g_bad_arb_mode
        $fatal(1, "stream_arb_mux_n: ARB_MODE must be 0 or 1");
    end

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [SEL_W-1:0]      out_src_q, out_src_d;
    logic [SEL_W-1:0]      ptr_q, ptr_d;
    logic                  lock_q, lock_d;
    logic [SEL_W-1:0]      lock_idx_q, lock_idx_d;

    logic                  load_en;
    logic                  grant_valid;
    logic [SEL_W-1:0]      grant_idx;
    logic                  xfer;

    // Source index at a given offset from the round-robin pointer, wrapping at NUM_INPUTS.
    function automatic int rr_idx(input logic [SEL_W-1:0] ptr, input int off);
        int idx;
        idx = int'(ptr) + off;
        if (idx >= NUM_INPUTS) begin
            idx = idx - NUM_INPUTS;
        end
        return idx;
    endfunction

    assign load_en = !out_valid_q || i_out_ready;

    // Descending scans so the final assignment is the highest-priority candidate.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (lock_q) begin
            grant_valid = 1'b1;
            grant_idx   = lock_idx_q;
        end else if (ARB_MODE == 1) begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                if (i_in_valid[k]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(k);
                end
            end
        end else begin
            for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
                if (i_in_valid[rr_idx(ptr_q, i)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(rr_idx(ptr_q, i));
                end
            end
        end
    end

    always_comb begin
        o_in_ready = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            o_in_ready[k] = !i_rst && load_en && grant_valid && (grant_idx == SEL_W'(k));
        end
    end

    assign xfer = |(i_in_valid & o_in_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        ptr_d       = ptr_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = i_in_data[grant_idx];
            out_last_d  = i_in_last[grant_idx];
            out_src_d   = grant_idx;
        end else if (i_out_ready) begin
            out_valid_d = 1'b0;
        end

        if (LOCK_PACKETS != 0 && xfer) begin
            lock_d     = !i_in_last[grant_idx];
            lock_idx_d = grant_idx;
        end

        // Pointer only advances once the source releases the grant.
        if (ARB_MODE == 0 && xfer && !lock_d) begin
            ptr_d = (grant_idx == SEL_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
        end
    end

    assign o_out_valid = out_valid_q;
    assign o_out_data  = out_data_q;
    assign o_out_last  = out_last_q;
    assign o_out_src   = out_src_q;

endmodule

// File: tb/tb_stream_arb_mux_n.sv
// Directed bench for stream_arb_mux_n: three configurations (RR+lock, fixed priority, 3-input RR).
module tb_stream_arb_mux_n;

    logic clk;
    logic rst;

    logic [3:0]        a_valid, a_ready, a_last;
    logic [3:0][31:0]  a_data;
    logic              a_out_valid, a_out_ready, a_out_last;
    logic [31:0]       a_out_data;
    logic [1:0]        a_out_src;

    logic [3:0]        b_valid, b_ready, b_last;
    logic [3:0][31:0]  b_data;
    logic              b_out_valid, b_out_ready, b_out_last;
    logic [31:0]       b_out_data;
    logic [1:0]        b_out_src;

    logic [2:0]        c_valid, c_ready, c_last;
    logic [2:0][31:0]  c_data;
    logic              c_out_valid, c_out_ready, c_out_last;
    logic [31:0]       c_out_data;
    logic [1:0]        c_out_src;

    int n_vec;
    int n_err;

    stream_arb_mux_n #(.NUM_INPUTS(4), .DATA_WIDTH(32), .ARB_MODE(0), .LOCK_PACKETS(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_in_valid(a_valid), .o_in_ready(a_ready),
        .i_in_data(a_data), .i_in_last(a_last), .o_out_valid(a_out_valid),
        .i_out_ready(a_out_ready), .o_out_data(a_out_data), .o_out_last(a_out_last),
        .o_out_src(a_out_src)
    );

    stream_arb_mux_n #(.NUM_INPUTS(4), .DATA_WIDTH(32), .ARB_MODE(1), .LOCK_PACKETS(0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_in_valid(b_valid), .o_in_ready(b_ready),
        .i_in_data(b_data), .i_in_last(b_last), .o_out_valid(b_out_valid),
        .i_out_ready(b_out_ready), .o_out_data(b_out_data), .o_out_last(b_out_last),
        .o_out_src(b_out_src)
    );

    stream_arb_mux_n #(.NUM_INPUTS(3), .DATA_WIDTH(32), .ARB_MODE(0), .LOCK_PACKETS(0)) u_dut_c (
        .i_clk(clk), .i_rst(rst), .i_in_valid(c_valid), .o_in_ready(c_ready),
        .i_in_data(c_data), .i_in_last(c_last), .o_out_valid(c_out_valid),
        .i_out_ready(c_out_ready), .o_out_data(c_out_data), .o_out_last(c_out_last),
        .o_out_src(c_out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        a_valid = 4'b1111; a_last = 4'b1111; a_out_ready = 1'b1;
        a_data = {32'h103, 32'h102, 32'h101, 32'h100};
        b_valid = 4'b0000; b_last = 4'b0000; b_out_ready = 1'b1;
        b_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        c_valid = 3'b000; c_last = 3'b000; c_out_ready = 1'b1;
        c_data = {32'hC2, 32'hC1, 32'hC0};

        // Reset state
        tick;
        tick;
        check("rst_a_valid", 32'(a_out_valid), 32'd0);
        check("rst_a_data", a_out_data, 32'd0);
        check("rst_a_last", 32'(a_out_last), 32'd0);
        check("rst_a_src", 32'(a_out_src), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_valid", 32'(b_out_valid), 32'd0);
        check("rst_c_valid", 32'(c_out_valid), 32'd0);
        rst = 1'b0;

        // Round-robin, all requesting, one beat per cycle
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr4_ready", 32'(a_ready), 32'(1 << (i % 4)));
            tick;
            check("rr4_src", 32'(a_out_src), 32'(i % 4));
            check("rr4_data", a_out_data, 32'h100 + 32'(i % 4));
            check("rr4_valid", 32'(a_out_valid), 32'd1);
        end
        a_valid = 4'b0000;

        // Fixed priority: src1 beats src3 until it drops
        b_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fp_ready", 32'(b_ready), 32'h2);
            tick;
            check("fp_src", 32'(b_out_src), 32'd1);
        end
        b_valid = 4'b1000;
        #1;
        check("fp_ready3", 32'(b_ready), 32'h8);
        tick;
        check("fp_src3", 32'(b_out_src), 32'd3);
        check("fp_data3", b_out_data, 32'hB3);
        b_valid = 4'b0000;

        // Three inputs: wrap 2 -> 0
        c_valid = 3'b111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr3_ready", 32'(c_ready), 32'(1 << (i % 3)));
            tick;
            check("rr3_src", 32'(c_out_src), 32'(i % 3));
        end
        c_valid = 3'b000;

        // Packet lock: src2 3-beat packet while src0 waits (ptr is 1 here)
        a_valid = 4'b0101; a_last = 4'b0001;
        a_data[0] = 32'h100; a_data[2] = 32'h200;
        #1;
        check("lock_ready0", 32'(a_ready), 32'h4);
        tick;
        check("lock_src0", 32'(a_out_src), 32'd2);
        check("lock_last0", 32'(a_out_last), 32'd0);
        a_valid = 4'b0001;
        #1;
        check("lock_gap_ready", 32'(a_ready), 32'h4);
        tick;
        check("lock_gap_valid", 32'(a_out_valid), 32'd0);
        a_valid = 4'b0101; a_data[2] = 32'h201;
        #1;
        check("lock_ready1", 32'(a_ready), 32'h4);
        tick;
        check("lock_data1", a_out_data, 32'h201);
        a_data[2] = 32'h202; a_last[2] = 1'b1;
        #1;
        check("lock_ready2", 32'(a_ready), 32'h4);
        tick;
        check("lock_data2", a_out_data, 32'h202);
        check("lock_last2", 32'(a_out_last), 32'd1);
        a_valid = 4'b1001; a_last = 4'b1111; a_data[3] = 32'h103;
        #1;
        check("ptr3_ready", 32'(a_ready), 32'h8);
        tick;
        check("ptr3_src", 32'(a_out_src), 32'd3);
        a_valid = 4'b0001;
        #1;
        check("after_ready", 32'(a_ready), 32'h1);
        tick;
        check("after_src", 32'(a_out_src), 32'd0);

        // Backpressure (ptr is 1 here)
        a_valid = 4'b0010; a_data[1] = 32'hDEADBEEF;
        tick;
        check("bp_load", a_out_data, 32'hDEADBEEF);
        a_out_ready = 1'b0; a_data[1] = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready", 32'(a_ready), 32'd0);
            tick;
            check("bp_valid", 32'(a_out_valid), 32'd1);
            check("bp_data", a_out_data, 32'hDEADBEEF);
            check("bp_src", 32'(a_out_src), 32'd1);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(a_ready), 32'h2);
        tick;
        check("bp_rel_data", a_out_data, 32'h11111111);

        // Reset while locked on src1
        a_data[1] = 32'h300; a_last[1] = 1'b0;
        tick;
        check("mid_lock_data", a_out_data, 32'h300);
        a_valid = 4'b0011;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(a_ready), 32'd0);
        tick;
        check("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_data", a_out_data, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(a_ready), 32'h1);
        tick;
        check("post_rst_src", 32'(a_out_src), 32'd0);
        check("post_rst_data", a_out_data, 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
